// File: rtl/vga_tile_renderer_if.sv
// Memory-read and video-output bundle between the tile renderer (master)
// and the board RAM, sprite ROM and display sink (slave).
interface vga_tile_renderer_if #(
    parameter int BOARD_AW = 11,
    parameter int CODE_W   = 4,
    parameter int SPR_AW   = 13
);
    logic [BOARD_AW-1:0] board_addr;
    logic [CODE_W-1:0]   board_code;
    logic [CODE_W-1:0]   spr_code;
    logic [SPR_AW-1:0]   spr_addr;
    logic [11:0]         spr_rgb;
    logic                hs;
    logic                vs;
    logic                de;
    logic [11:0]         rgb;
    logic                frame_start;

    modport master (
        output board_addr, spr_code, spr_addr, hs, vs, de, rgb, frame_start,
        input  board_code, spr_rgb
    );

    modport slave (
        input  board_addr, spr_code, spr_addr, hs, vs, de, rgb, frame_start,
        output board_code, spr_rgb
    );
endinterface

// File: rtl/vga_tile_renderer.sv
// VGA raster timing plus a divider-free tile-grid pixel pipeline: raster counters
// feed board-RAM and sprite-ROM lookups, and colour comes out registered with sync aligned.
module vga_tile_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int GRID_N   = 4,
    parameter int TILE     = 90,
    parameter int GAP      = 20,
    parameter int ORG_X    = 40,
    parameter int ORG_Y    = 30,
    parameter int BOARD_AW = 11,
    parameter logic [BOARD_AW-1:0] BOARD_BASE = 11'h256,
    parameter int CODE_W   = 4,
    parameter int SPR_AW   = 13,
    parameter int MEM_LAT  = 1,
    parameter logic [11:0] BG_RGB    = 12'h000,
    parameter logic [11:0] EMPTY_RGB = 12'hBBB
) (
    input  logic                clk,
    input  logic                rst,
    vga_tile_renderer_if.master bus
);
    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(HT + 1);
    localparam int VW    = $clog2(VT + 1);
    localparam int PITCH = TILE + GAP;
    localparam int PW    = $clog2(PITCH + 1);
    localparam int CW    = $clog2(GRID_N + 1);
    localparam int L     = 2 + 2 * MEM_LAT;

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ORG  = HW'(ORG_X);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ORG  = VW'(ORG_Y);
    localparam logic [PW-1:0] P_LAST = PW'(PITCH - 1);
    localparam logic [PW-1:0] T_SZ   = PW'(TILE);
    localparam logic [PW-1:0] T_LAST = PW'(TILE - 1);
    localparam logic [CW-1:0] G_N    = CW'(GRID_N);
    localparam logic [SPR_AW-1:0]   T_STEP = SPR_AW'(TILE);
    localparam logic [BOARD_AW-1:0] R_STEP = BOARD_AW'(GRID_N);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic in_tile;
    } vid_t;

    localparam vid_t VID_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, in_tile: 1'b0};

    logic [HW-1:0]       h_r, h_nxt_s;
    logic [VW-1:0]       v_r, v_nxt_s;
    logic [PW-1:0]       px_r, px_nxt_s, py_r, py_nxt_s;
    logic [CW-1:0]       col_r, col_nxt_s, row_r, row_nxt_s;
    logic                in_x_r, in_x_nxt_s, in_y_r, in_y_nxt_s;
    logic [BOARD_AW-1:0] row_base_r, row_base_nxt_s;
    logic [SPR_AW-1:0]   line_off_r, line_off_nxt_s;

    vid_t                vid_s;
    logic [SPR_AW-1:0]   off_s;
    logic [BOARD_AW-1:0] idx_s;
    logic [CODE_W-1:0]   spr_code_s;
    logic [11:0]         rgb_nxt_s;

    vid_t                dly_r   [1:L];
    logic [SPR_AW-1:0]   off_r   [1:MEM_LAT+1];
    logic [CODE_W-1:0]   code_r  [1:MEM_LAT];
    logic [BOARD_AW-1:0] board_addr_r;
    logic [11:0]         rgb_r;
    logic                frame_start_r;

    // Next state of the raster counters and the running cell/offset trackers
    always_comb begin
        if (h_r == H_LAST) begin
            h_nxt_s = HW'(0);
        end else begin
            h_nxt_s = h_r + HW'(1);
        end

        // Horizontal tracking restarts at the grid origin and saturates once col reaches GRID_N
        if (h_nxt_s <= H_ORG) begin
            px_nxt_s  = PW'(0);
            col_nxt_s = CW'(0);
        end else if (col_r < G_N) begin
            if (px_r == P_LAST) begin
                px_nxt_s  = PW'(0);
                col_nxt_s = col_r + CW'(1);
            end else begin
                px_nxt_s  = px_r + PW'(1);
                col_nxt_s = col_r;
            end
        end else begin
            px_nxt_s  = px_r;
            col_nxt_s = col_r;
        end
        in_x_nxt_s = (h_nxt_s >= H_ORG) && (px_nxt_s < T_SZ) && (col_nxt_s < G_N);

        v_nxt_s        = v_r;
        py_nxt_s       = py_r;
        row_nxt_s      = row_r;
        row_base_nxt_s = row_base_r;
        line_off_nxt_s = line_off_r;
        in_y_nxt_s     = in_y_r;
        if (h_r == H_LAST) begin
            if (v_r == V_LAST) begin
                v_nxt_s = VW'(0);
            end else begin
                v_nxt_s = v_r + VW'(1);
            end
            if (v_nxt_s <= V_ORG) begin
                py_nxt_s       = PW'(0);
                row_nxt_s      = CW'(0);
                row_base_nxt_s = BOARD_AW'(0);
                line_off_nxt_s = SPR_AW'(0);
            end else if (row_r < G_N) begin
                if (py_r == P_LAST) begin
                    py_nxt_s       = PW'(0);
                    row_nxt_s      = row_r + CW'(1);
                    row_base_nxt_s = row_base_r + R_STEP;
                    line_off_nxt_s = SPR_AW'(0);
                end else begin
                    py_nxt_s = py_r + PW'(1);
                    // line offset stops growing inside the gap so it never overflows
                    if (py_r < T_LAST) begin
                        line_off_nxt_s = line_off_r + T_STEP;
                    end else begin
                        line_off_nxt_s = line_off_r;
                    end
                end
            end else begin
                py_nxt_s  = py_r;
                row_nxt_s = row_r;
            end
            in_y_nxt_s = (v_nxt_s >= V_ORG) && (py_nxt_s < T_SZ) && (row_nxt_s < G_N);
        end else begin
            in_y_nxt_s = in_y_r;
        end
    end

    // Raster counters and cell trackers (pipeline stage S0)
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r        <= HW'(0);
            v_r        <= VW'(0);
            px_r       <= PW'(0);
            py_r       <= PW'(0);
            col_r      <= CW'(0);
            row_r      <= CW'(0);
            row_base_r <= BOARD_AW'(0);
            line_off_r <= SPR_AW'(0);
            in_x_r     <= (H_ORG == HW'(0));
            in_y_r     <= (V_ORG == VW'(0));
        end else begin
            h_r        <= h_nxt_s;
            v_r        <= v_nxt_s;
            px_r       <= px_nxt_s;
            py_r       <= py_nxt_s;
            col_r      <= col_nxt_s;
            row_r      <= row_nxt_s;
            row_base_r <= row_base_nxt_s;
            line_off_r <= line_off_nxt_s;
            in_x_r     <= in_x_nxt_s;
            in_y_r     <= in_y_nxt_s;
        end
    end

    // S0 decode: raw syncs, display enable, tile membership, cell index and sprite offset
    always_comb begin
        vid_s.hs      = !((h_r >= HS_BEG) && (h_r < HS_END));
        vid_s.vs      = !((v_r >= VS_BEG) && (v_r < VS_END));
        vid_s.de      = (h_r < H_ACT) && (v_r < V_ACT);
        vid_s.in_tile = vid_s.de && in_x_r && in_y_r;
        off_s         = line_off_r + SPR_AW'(px_r);
        idx_s         = row_base_r + BOARD_AW'(col_r);
    end

    // Sprite select follows board data only while the aligned pixel lies in a tile
    always_comb begin
        if (dly_r[1+MEM_LAT].in_tile) begin
            spr_code_s = bus.board_code;
        end else begin
            spr_code_s = CODE_W'(0);
        end
    end

    // Colour select at the stage where sprite data returns
    always_comb begin
        if (!dly_r[L-1].de) begin
            rgb_nxt_s = 12'h000;
        end else if (!dly_r[L-1].in_tile) begin
            rgb_nxt_s = BG_RGB;
        end else if (code_r[MEM_LAT] == CODE_W'(0)) begin
            rgb_nxt_s = EMPTY_RGB;
        end else begin
            rgb_nxt_s = bus.spr_rgb;
        end
    end

    // Delay lines, memory addresses and registered video outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= L; k++) begin
                dly_r[k] <= VID_RST;
            end
            for (int k = 1; k <= MEM_LAT + 1; k++) begin
                off_r[k] <= SPR_AW'(0);
            end
            for (int k = 1; k <= MEM_LAT; k++) begin
                code_r[k] <= CODE_W'(0);
            end
            board_addr_r  <= BOARD_BASE;
            rgb_r         <= 12'h000;
            frame_start_r <= 1'b0;
        end else begin
            dly_r[1] <= vid_s;
            for (int k = 2; k <= L; k++) begin
                dly_r[k] <= dly_r[k-1];
            end
            off_r[1] <= vid_s.in_tile ? off_s : SPR_AW'(0);
            for (int k = 2; k <= MEM_LAT + 1; k++) begin
                off_r[k] <= off_r[k-1];
            end
            code_r[1] <= spr_code_s;
            for (int k = 2; k <= MEM_LAT; k++) begin
                code_r[k] <= code_r[k-1];
            end
            // address holds its last in-tile value so the RAM sees no spurious reads
            board_addr_r  <= vid_s.in_tile ? (BOARD_BASE + idx_s) : board_addr_r;
            rgb_r         <= rgb_nxt_s;
            frame_start_r <= (h_r == HW'(0)) && (v_r == VW'(0));
        end
    end

    assign bus.board_addr  = board_addr_r;
    assign bus.spr_code    = spr_code_s;
    assign bus.spr_addr    = off_r[MEM_LAT+1];
    assign bus.hs          = dly_r[L].hs;
    assign bus.vs          = dly_r[L].vs;
    assign bus.de          = dly_r[L].de;
    assign bus.rgb         = rgb_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer on a shrunken raster (5x5 grid, MEM_LAT=2)
// with randomized board contents, clipped edge tiles and a mid-frame reset.
module tb_vga_tile_renderer;
    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 6;
    localparam int VA = 48, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int GN = 5, TL = 7, GP = 3, OX = 20, OY = 10;
    localparam int PITCH = TL + GP;
    localparam int BAW = 11, CDW = 4, SAW = 8, ML = 2;
    localparam int L = 2 + 2 * ML;
    localparam logic [10:0] BASE  = 11'h256;
    localparam logic [11:0] BG_C  = 12'h123;
    localparam logic [11:0] EMP_C = 12'hBBB;

    typedef struct {
        logic hs, vs, de, in_tile, fs;
        int   idx, off;
    } px_t;
    typedef struct packed { logic [10:0] addr; logic fs; } b_t;
    typedef struct packed { logic [7:0] addr; logic [3:0] code; logic chk_code; } s_t;
    typedef struct packed { logic hs; logic vs; logic de; logic [11:0] rgb; } v_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_tile_renderer_if #(.BOARD_AW(BAW), .CODE_W(CDW), .SPR_AW(SAW)) bus ();

    vga_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .GRID_N(GN), .TILE(TL), .GAP(GP), .ORG_X(OX), .ORG_Y(OY),
        .BOARD_AW(BAW), .BOARD_BASE(BASE), .CODE_W(CDW), .SPR_AW(SAW),
        .MEM_LAT(ML), .BG_RGB(BG_C), .EMPTY_RGB(EMP_C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [3:0]  board_mem [0:2047];
    logic [3:0]  bpipe [1:ML];
    logic [11:0] spipe [1:ML];

    function automatic logic [11:0] rom(input logic [3:0] c, input logic [7:0] a);
        logic [11:0] r;
        r = ({c, a} * 12'd29) ^ 12'h5A5;
        return r;
    endfunction

    // Board RAM and sprite ROM with ML cycles of read latency
    always @(posedge clk) begin
        bpipe[1] <= board_mem[bus.board_addr];
        spipe[1] <= rom(bus.spr_code, bus.spr_addr);
        for (int k = 2; k <= ML; k++) begin
            bpipe[k] <= bpipe[k-1];
            spipe[k] <= spipe[k-1];
        end
    end
    assign bus.board_code = bpipe[ML];
    assign bus.spr_rgb    = spipe[ML];

    int checks = 0;
    int passes = 0;
    int n_drv  = 0;
    bit live   = 1'b0;
    bit in_rst = 1'b0;
    logic [10:0] last_addr;
    b_t bq[$];
    s_t sq[$];
    v_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, n_drv, act, exp);
    endtask

    // Reference pixel from raster position with plain division/modulo
    function automatic px_t model(input int n);
        px_t p;
        int h, v, cx, cy;
        h = n % HT;
        v = (n / HT) % VT;
        p.de = (h < HA) && (v < VA);
        p.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
        p.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
        p.fs = (h == 0) && (v == 0);
        cx = h - OX;
        cy = v - OY;
        p.in_tile = p.de && cx >= 0 && cy >= 0 && (cx / PITCH) < GN && (cy / PITCH) < GN
                    && (cx % PITCH) < TL && (cy % PITCH) < TL;
        p.idx = (cy / PITCH) * GN + cx / PITCH;
        p.off = (cy % PITCH) * TL + cx % PITCH;
        return p;
    endfunction

    task automatic push(input int n);
        px_t p;
        int a;
        logic [3:0] code;
        b_t be; s_t se; v_t ve;
        p = model(n);
        a = 32'(BASE) + p.idx;
        code = 4'd0;
        if (p.in_tile) begin
            last_addr = a[10:0];
            code = board_mem[a[10:0]];
        end
        be.addr = last_addr; be.fs = p.fs;
        se.addr = p.in_tile ? 8'(p.off) : 8'd0; se.code = code; se.chk_code = p.in_tile;
        ve.hs = p.hs; ve.vs = p.vs; ve.de = p.de;
        if (!p.de) ve.rgb = 12'h000;
        else if (!p.in_tile) ve.rgb = BG_C;
        else if (code == 4'd0) ve.rgb = EMP_C;
        else ve.rgb = rom(code, 8'(p.off));
        bq.push_back(be);
        sq.push_back(se);
        vq.push_back(ve);
        n_drv = n;
    endtask

    task automatic do_reset(input int cycles);
        live = 1'b0;
        rst  = 1'b1;
        bq.delete(); sq.delete(); vq.delete();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            in_rst = 1'b1;
        end
    endtask

    task automatic run(input int ncyc);
        last_addr = BASE;
        rst    = 1'b0;
        in_rst = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            push(n);
            live = 1'b1;
        end
    endtask

    // Monitor: pops expected values at each output's own latency and compares
    always @(negedge clk) begin
        b_t be; s_t se; v_t ve;
        if (live) begin
            if (n_drv >= 1) begin
                chk("board_q", 32'(bq.size() > 0), 32'd1);
                if (bq.size() > 0) begin
                    be = bq.pop_front();
                    chk("board_addr", 32'(bus.board_addr), 32'(be.addr));
                    chk("frame_start", 32'(bus.frame_start), 32'(be.fs));
                end
            end
            if (n_drv >= 1 + ML && sq.size() > 0) begin
                se = sq.pop_front();
                chk("spr_addr", 32'(bus.spr_addr), 32'(se.addr));
                if (se.chk_code) chk("spr_code", 32'(bus.spr_code), 32'(se.code));
            end
            if (n_drv >= L && vq.size() > 0) begin
                ve = vq.pop_front();
                chk("sync_de", 32'({bus.hs, bus.vs, bus.de}), 32'({ve.hs, ve.vs, ve.de}));
                chk("rgb", 32'(bus.rgb), 32'(ve.rgb));
            end
        end else if (in_rst) begin
            chk("rst_sync", 32'({bus.hs, bus.vs, bus.de, bus.frame_start}), 32'(4'b1100));
            chk("rst_rgb", 32'(bus.rgb), 32'd0);
            chk("rst_addr", 32'({bus.board_addr, bus.spr_addr, bus.spr_code}), 32'({BASE, 8'd0, 4'd0}));
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2048; i++) board_mem[i] = 4'($urandom_range(0, 15));
        board_mem[BASE + 11'd0] = 4'd9;
        board_mem[BASE + 11'd3] = 4'd0;
        board_mem[BASE + 11'd5] = 4'd7;
        board_mem[BASE + 11'd24] = 4'd2;
        do_reset(4);
        // two full frames, then stop in the cycle where the counters sit at h=30, v=20
        run(2 * HT * VT + 20 * HT + 30 + 1);
        do_reset(3);
        run(HT * VT + 200);
        live = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
